// File: rtl/instr_loader.sv
// Byte-serial program loader: assembles little-endian words from rx bytes and writes them to
// instruction memory, holding the core in reset until a load completes. Optional macro:
// LOADER_CHECKSUM_EN adds a trailing XOR checksum byte verified in a CHECK state.
module instr_loader #(
  parameter int unsigned MEM_BYTES = 88,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  word_count,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  localparam int unsigned MaxWords = MEM_BYTES / 4;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StLoad, StWrite, StCheck, StDone, StErr} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StWrite, StDone, StErr} state_e;
`endif

  state_e      state_q, state_d;
  logic [7:0]  words_left_q;
  logic [63:0] addr_q;
  logic [1:0]  byte_idx_q;
  logic [31:0] word_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic count_ok;
  logic can_start;
  logic load_start;
  logic hs;

  assign count_ok   = (word_count != 8'd0) && ({24'd0, word_count} <= MaxWords);
  assign can_start  = (state_q == StIdle) || (state_q == StDone);
  assign load_start = can_start && start && count_ok;
  assign hs         = rx_valid && rx_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = count_ok ? StLoad : StErr;
        end
      end
      StLoad: begin
        if (hs && (byte_idx_q == 2'd3)) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        // words_left_q still holds the pre-decrement count here
        if (words_left_q != 8'd1) begin
          state_d = StLoad;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (hs) begin
          state_d = (rx_data == csum_q) ? StDone : StErr;
        end
      end
`endif
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    rx_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      StWrite: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      StDone: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      StErr:   error = 1'b1;
      default: ;
    endcase
  end

  // Datapath: address, word counter and byte assembly
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      words_left_q <= 8'd0;
      addr_q       <= 64'd0;
      byte_idx_q   <= 2'd0;
      word_q       <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      if (load_start) begin
        words_left_q <= word_count;
        addr_q       <= BASE_ADDR;
        byte_idx_q   <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
        csum_q       <= 8'd0;
`endif
      end
      if ((state_q == StLoad) && hs) begin
        word_q[{byte_idx_q, 3'b000} +: 8] <= rx_data;
        byte_idx_q                        <= byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        csum_q                            <= csum_q ^ rx_data;
`endif
      end
      if (state_q == StWrite) begin
        addr_q       <= addr_q + 64'd4;
        words_left_q <= words_left_q - 8'd1;
      end
    end
  end

  // Registered sources keep the write bus glitch-free between strobes
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed and randomized loads compared against a
// word-list model built from the byte stream; follows LOADER_CHECKSUM_EN when defined.
module tb_instr_loader;

  localparam int unsigned MemBytes = 88;
  localparam logic [63:0] Base     = 64'h0000_0000_0000_1000;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  word_count;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  instr_loader #(
    .MEM_BYTES(MemBytes),
    .BASE_ADDR(Base)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .word_count(word_count),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpu_hold  (cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [95:0] got_q[$];
  int cyc      = 0;
  int accepted = 0;
  int last_hs  = -10;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Handshake bookkeeping, observed at the active edge
  always @(posedge clk) begin
    if (!reset_n) begin
      accepted <= 0;
    end else if (rx_valid && rx_ready) begin
      accepted <= accepted + 1;
      last_hs  <= cyc;
    end
    cyc <= cyc + 1;
  end

  // Capture writes; each must land one cycle after a word-completing byte
  always @(negedge clk) begin
    if (mem_we) begin
      got_q.push_back({mem_addr, mem_wdata});
      check("we_after_4th_byte", 64'(last_hs), 64'(cyc - 1));
      check("we_word_aligned", 64'(accepted % 4), 64'd0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic start_pulse(input logic [7:0] wc);
    @(negedge clk);
    start      = 1'b1;
    word_count = wc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // gap < 0: rx_valid low every other cycle; otherwise percent chance of an idle cycle
  task automatic feed(input bq_t b, input int gap, input bit noisy, input string tag);
    int idx = 0;
    int n   = 0;
    bit took;
    while (idx < b.size() && n < 1000) begin
      @(negedge clk);
      if (noisy) begin
        start      = 1'($urandom_range(1));
        word_count = 8'($urandom_range(255));
      end
      if ((gap < 0) ? (n % 2 == 1) : (int'($urandom_range(99)) < gap)) begin
        rx_valid = 1'b0;
      end else begin
        rx_valid = 1'b1;
        rx_data  = b[idx];
      end
      took = rx_valid && rx_ready;
      @(posedge clk);
      if (took) idx++;
      n++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
    check({tag, "_bytes_fed"}, 64'(idx), 64'(b.size()));
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || error) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished"}, 64'(n < 100), 64'd1);
  endtask

  // Full load: model expects word i = bytes 4i..4i+3 little-endian at Base + 4i
  task automatic run_load(input logic [7:0] wc, input bq_t prog, input int gap, input bit noisy,
                          input bit bad_csum, input string tag);
    bq_t        stream;
    logic [7:0] x;
    bit         exp_ok;
    int         nw;
    stream = prog;
    x      = 8'd0;
    exp_ok = 1'b1;
    foreach (prog[i]) x ^= prog[i];
`ifdef LOADER_CHECKSUM_EN
    stream.push_back(bad_csum ? (x ^ 8'h01) : x);
    exp_ok = !bad_csum;
`endif
    got_q.delete();
    start_pulse(wc);
    check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    check({tag, "_hold_after_start"}, 64'(cpu_hold), 64'd1);
    feed(stream, gap, noisy, tag);
    wait_end(tag);
    check({tag, "_done"}, 64'(done), 64'(exp_ok));
    check({tag, "_error"}, 64'(error), 64'(!exp_ok));
    check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(!exp_ok));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    nw = prog.size() / 4;
    check({tag, "_n_writes"}, 64'(got_q.size()), 64'(nw));
    for (int i = 0; i < nw && i < got_q.size(); i++) begin
      check({tag, "_addr"}, got_q[i][95:32], Base + 64'(4 * i));
      check({tag, "_data"}, 64'(got_q[i][31:0]),
            64'({prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]}));
    end
  endtask

  initial begin
    bq_t p;
    logic [7:0] wc;
    reset_n    = 1'b0;
    start      = 1'b0;
    word_count = 8'd0;
    rx_data    = 8'd0;
    rx_valid   = 1'b0;
    do_reset();

    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);

    p = '{8'h13, 8'h09, 8'h00, 8'h00, 8'h33, 8'h04, 8'h00, 8'h00};
    run_load(8'd2, p, 0, 1'b0, 1'b0, "b2b");
    if (got_q.size() == 2) check("b2b_word0_literal", 64'(got_q[0][31:0]), 64'h0000_0913);
    run_load(8'd2, p, -1, 1'b0, 1'b0, "alt_valid");

    for (int t = 0; t < 5; t++) begin
      wc = (t == 4) ? 8'(MemBytes / 4) : 8'($urandom_range(1, 6));
      p.delete();
      for (int i = 0; i < 4 * int'(wc); i++) p.push_back(8'($urandom_range(255)));
      run_load(wc, p, int'($urandom_range(60)), 1'b1, 1'b0, "rand");
    end

    // Reset after two bytes of the first word
    got_q.delete();
    start_pulse(8'd1);
    p = '{8'hAA, 8'hBB};
    feed(p, 0, 1'b0, "partial");
    do_reset();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("midrst_rx_ready", 64'(rx_ready), 64'd0);
    check("midrst_no_write", 64'(got_q.size()), 64'd0);
    p = '{8'h93, 8'h00, 8'h10, 8'h00};
    run_load(8'd1, p, 0, 1'b0, 1'b0, "reload");

`ifdef LOADER_CHECKSUM_EN
    p = '{8'h13, 8'h09, 8'h00, 8'h00};
    run_load(8'd1, p, 0, 1'b0, 1'b0, "csum_good");
    run_load(8'd1, p, 0, 1'b0, 1'b1, "csum_bad");
`endif

    // Rejected counts, then sticky error
    do_reset();
    got_q.delete();
    start_pulse(8'd0);
    check("wc0_error", 64'(error), 64'd1);
    check("wc0_hold", 64'(cpu_hold), 64'd1);
    @(negedge clk);
    start      = 1'b1;
    word_count = 8'd1;
    rx_valid   = 1'b1;
    repeat (3) @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    check("err_sticky", 64'(error), 64'd1);
    check("err_no_ready", 64'(rx_ready), 64'd0);
    check("err_not_busy", 64'(busy), 64'd0);
    check("wc0_no_write", 64'(got_q.size()), 64'd0);

    do_reset();
    check("err_cleared", 64'(error), 64'd0);
    start_pulse(8'(MemBytes / 4 + 1));
    check("wc_over_error", 64'(error), 64'd1);
    repeat (3) @(negedge clk);
    check("wc_over_no_write", 64'(got_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 88: instruction memory size in bytes; multiple of 4.
REQ-002 SHALL have parameter BASE_ADDR, default 64'h0: byte address of the first word written.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request a program load; sampled in IDLE/DONE only.
REQ-006 SHALL have port word_count  input  8  number of 32-bit words to load; sampled with start.
REQ-007 SHALL have port rx_data  input  8  incoming program byte.
REQ-008 SHALL have port rx_valid  input  1  rx_data valid.
REQ-009 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port mem_we  output  1  instruction-memory word write strobe.
REQ-011 SHALL have port mem_addr  output  64  byte address of the write; word-aligned.
REQ-012 SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  load completed successfully.
REQ-015 SHALL have port error  output  1  load rejected or failed; sticky.
REQ-016 SHALL have port cpu_hold  output  1  holds the core and PC in reset until a program is loaded.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, WRITE, CHECK, DONE, and ERR.
REQ-018 IDLE/DONE SHALL work as follows: when start=1 and 1 <= word_count <= MEM_BYTES/4, latch the count, set addr=BASE_ADDR, clear byte_idx, and go to LOAD; when start=1 with word_count=0 or above the limit, go to ERR.
REQ-019 A byte SHALL transfer only when rx_valid & rx_ready; rx_valid with rx_ready=0 SHALL be ignored and the byte is not consumed.
REQ-020 rx_ready SHALL be 1 only in LOAD, and in CHECK when configured.
REQ-021 Assembly SHALL be little-endian: byte k of a word goes to bits [8k+7:8k]; byte_idx wraps 3 to 0.
REQ-022 On the 4th accepted byte, the next state SHALL be WRITE, so mem_we rises exactly 1 cycle after that byte's handshake.
REQ-023 WRITE SHALL assert mem_we for exactly 1 cycle with mem_addr=addr and mem_wdata=the assembled word, then set addr+=4 and decrement words_left.
REQ-024 From WRITE the FSM SHALL go to LOAD if words_left is nonzero; otherwise it goes to CHECK (macro defined) or DONE.
REQ-025 mem_addr and mem_wdata SHALL be don't-care when mem_we=0 but held stable (no glitching); maximum throughput is one word per 5 cycles.
REQ-026 busy SHALL be 1 in LOAD, WRITE, and CHECK.
REQ-027 done SHALL be 1 only in DONE.
REQ-028 error SHALL be 1 only in ERR, and ERR SHALL exit only via reset.
REQ-029 cpu_hold SHALL be 0 only in DONE; a restart from DONE raises cpu_hold the next cycle.
REQ-030 start SHALL be ignored while busy or in ERR.

Reset
REQ-031 reset_n=0 at a clock edge SHALL force IDLE with rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, and cpu_hold=1.
REQ-032 Reset mid-load SHALL discard any partial word, issue no write, and clear the checksum and counters.

Configuration
REQ-033 Macro LOADER_CHECKSUM_EN defined: the loader SHALL keep a running XOR of all program bytes, and CHECK SHALL accept one extra byte.
REQ-034 With LOADER_CHECKSUM_EN defined, a checksum byte equal to the running XOR SHALL go to DONE and a mismatch SHALL go to ERR; words already written remain in memory.
REQ-035 Macro LOADER_CHECKSUM_EN undefined: the CHECK state and XOR logic SHALL be absent, and the last WRITE SHALL go directly to DONE.

Verification
REQ-036 word_count=2, bytes 13 09 00 00 33 04 00 00 back-to-back SHALL produce mem_we at addr 0 with data 32'h00000913, then at addr 4 with data 32'h00000433, then done=1 and cpu_hold=0.
REQ-037 Same stream with rx_valid low every other cycle SHALL produce identical writes, with no byte lost or duplicated.
REQ-038 start with word_count=0, and separately word_count=23, SHALL set error=1 with no mem_we; a later start SHALL be ignored until reset.
REQ-039 reset_n=0 after 2 bytes of word 0 SHALL give IDLE and cpu_hold=1; a reload of 1 word SHALL write the correct word at BASE_ADDR.
REQ-040 With LOADER_CHECKSUM_EN, bytes 13 09 00 00 plus checksum 1A SHALL give done=1, and checksum 1B SHALL give error=1.
REQ-041 start asserted during LOAD SHALL have no effect on the count, the address, or the writes.
